// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled one-shot/periodic timer control stage that drives an
// external up/down counter (clr/en/load/down/dat) and watches its value and
// overflow flag to produce a terminal-count irq and a sticky error flag.
module timer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int PSCR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  mode_i,
  input  logic                  dir_i,
  input  logic [DATA_WIDTH-1:0] reload_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic [DATA_WIDTH-1:0] cnt_dat_i,
  input  logic                  cnt_ovf_i,
  output logic                  cnt_clr_o,
  output logic                  cnt_en_o,
  output logic                  cnt_load_o,
  output logic                  cnt_down_o,
  output logic [DATA_WIDTH-1:0] cnt_dat_o,
  output logic                  busy_o,
  output logic                  irq_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t                  state;
  logic                    mode_q;
  logic                    dir_q;
  logic [DATA_WIDTH-1:0]   reload_q;
  logic [PSCR_WIDTH-1:0]   pscr_q;
  logic [PSCR_WIDTH-1:0]   psc_q;
  logic                    irq_q;
  logic                    err_q;

  logic                    tick;
  logic                    term;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   term_val;

  // Direction selects the load value and the terminal value; prescaler tick
  // and terminal detection only exist while running.
  always_comb begin
    load_val = dir_q ? reload_q : '0;
    term_val = dir_q ? '0 : reload_q;
    tick     = (state == RUN) && (psc_q == pscr_q);
    term     = tick && (cnt_dat_i == term_val);
  end

  // Counter command decode. stop_i clears in the same cycle; any start_i or
  // stop_i suppresses en/load so clr/en/load can never overlap.
  always_comb begin
    cnt_clr_o  = stop_i;
    cnt_en_o   = 1'b0;
    cnt_load_o = 1'b0;
    if (!stop_i && !start_i) begin
      case (state)
        LOAD: cnt_load_o = 1'b1;
        RUN: begin
          if (term && mode_q) begin
            cnt_load_o = 1'b1;
          end else if (tick && !term) begin
            cnt_en_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt_dat_o  = load_val;
  assign cnt_down_o = dir_q;
  assign busy_o     = (state != IDLE);
  assign irq_o      = irq_q;
  assign err_o      = err_q;

  // Timer FSM with prescaler, shadow config, irq pulse and sticky error.
  // A start_i that coincides with stop_i is ignored entirely (no config
  // sample, no error clear).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      psc_q    <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      reload_q <= '0;
      pscr_q   <= '0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if ((state == RUN) && cnt_ovf_i) begin
        err_q <= 1'b1;
      end
      if (stop_i) begin
        state <= IDLE;
        psc_q <= '0;
      end else if (start_i) begin
        state    <= LOAD;
        psc_q    <= '0;
        mode_q   <= mode_i;
        dir_q    <= dir_i;
        reload_q <= reload_i;
        pscr_q   <= pscr_i;
        err_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: psc_q <= '0;
          LOAD: begin
            psc_q <= '0;
            state <= RUN;
          end
          RUN: begin
            if (term) begin
              irq_q <= 1'b1;
              psc_q <= '0;
              if (!mode_q) begin
                state <= IDLE;
              end
            end else if (tick) begin
              psc_q <= '0;
            end else begin
              psc_q <= psc_q + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            psc_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: table-driven per-cycle vectors for timer_ctrl attached to a
// behavioural 16-bit up/down counter, plus a hand-written irq interval check.
module tb_timer_ctrl;

  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          mode;
  logic          dir;
  logic [DW-1:0] reload;
  logic [PW-1:0] pscr;
  logic [DW-1:0] cnt_q;
  logic          cnt_ovf;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_load;
  logic          cnt_down;
  logic [DW-1:0] cnt_dat;
  logic          busy;
  logic          irq;
  logic          err;
  logic          ovf_force;
  logic          wrap_q;
  logic          rst_n;

  always #5 clk = ~clk;

  timer_ctrl #(.DATA_WIDTH(DW), .PSCR_WIDTH(PW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .stop_i     (stop),
    .mode_i     (mode),
    .dir_i      (dir),
    .reload_i   (reload),
    .pscr_i     (pscr),
    .cnt_dat_i  (cnt_q),
    .cnt_ovf_i  (cnt_ovf),
    .cnt_clr_o  (cnt_clr),
    .cnt_en_o   (cnt_en),
    .cnt_load_o (cnt_load),
    .cnt_down_o (cnt_down),
    .cnt_dat_o  (cnt_dat),
    .busy_o     (busy),
    .irq_o      (irq),
    .err_o      (err)
  );

  // Behavioural counter with active-low synchronous reset.
  assign rst_n   = ~rst;
  assign cnt_ovf = wrap_q | ovf_force;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_load) cnt_q <= cnt_dat;
      else if (cnt_en) begin
        cnt_q  <= cnt_down ? cnt_q - 1'b1 : cnt_q + 1'b1;
        wrap_q <= cnt_down ? (cnt_q == '0) : (cnt_q == '1);
      end
    end
  end

  typedef struct {
    logic          start, stop, rst, ovf;
    logic          mode, dir;
    logic [DW-1:0] reload;
    logic [PW-1:0] pscr;
    logic          busy, irq, err, clr, en, load, down;
    logic [DW-1:0] cnt;
    logic [DW-1:0] ldv;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  logic          cur_mode;
  logic          cur_dir;
  logic [DW-1:0] cur_reload;
  logic [PW-1:0] cur_pscr;
  logic [DW-1:0] cur_ldv;

  int n_chk  = 0;
  int n_fail = 0;
  int cur_idx = 0;

  task automatic set_cfg(input logic m, input logic d, input int r, input int p, input int l);
    cur_mode   = m;
    cur_dir    = d;
    cur_reload = DW'(r);
    cur_pscr   = PW'(p);
    cur_ldv    = DW'(l);
  endtask

  // ins = {start, stop, rst, ovf}; outs = {busy, irq, err, clr, en, load, down}
  task automatic v(input logic [3:0] ins, input logic [6:0] outs, input int cv);
    vec_t r;
    r.start  = ins[3];
    r.stop   = ins[2];
    r.rst    = ins[1];
    r.ovf    = ins[0];
    r.mode   = cur_mode;
    r.dir    = cur_dir;
    r.reload = cur_reload;
    r.pscr   = cur_pscr;
    r.busy   = outs[6];
    r.irq    = outs[5];
    r.err    = outs[4];
    r.clr    = outs[3];
    r.en     = outs[2];
    r.load   = outs[1];
    r.down   = outs[0];
    r.cnt    = DW'(cv);
    r.ldv    = cur_ldv;
    tbl.push_back(r);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %b, expected %b", nm, cur_idx, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", nm, cur_idx, act, exp);
    end
  endtask

  task automatic fill_table();
    // idle after reset
    set_cfg(1'b0, 1'b0, 0, 0, 0);
    v(4'b0000, 7'b0000000, 0);
    // 1: one-shot down, reload=3, pscr=1; later input changes ignored
    set_cfg(1'b0, 1'b1, 3, 1, 3);
    v(4'b1000, 7'b0000000, 0);
    set_cfg(1'b1, 1'b0, 7, 0, 3);
    v(4'b0000, 7'b1000011, 0);
    for (int k = 0; k < 3; k++) begin
      v(4'b0000, 7'b1000001, 3 - k);
      v(4'b0000, 7'b1000101, 3 - k);
    end
    v(4'b0000, 7'b1000001, 0);
    v(4'b0000, 7'b1000001, 0);
    v(4'b0000, 7'b0100001, 0);
    v(4'b0000, 7'b0000001, 0);
    // 2: periodic up, reload=4, pscr=0; then 4: stop
    set_cfg(1'b1, 1'b0, 4, 0, 0);
    v(4'b1000, 7'b0000001, 0);
    v(4'b0000, 7'b1000010, 0);
    for (int k = 0; k < 4; k++) v(4'b0000, 7'b1000100, k);
    v(4'b0000, 7'b1000010, 4);
    v(4'b0000, 7'b1100100, 0);
    for (int k = 1; k < 4; k++) v(4'b0000, 7'b1000100, k);
    v(4'b0000, 7'b1000010, 4);
    v(4'b0000, 7'b1100100, 0);
    v(4'b0000, 7'b1000100, 1);
    v(4'b0100, 7'b1001000, 2);
    v(4'b0000, 7'b0000000, 0);
    // 3: periodic reload=0, pscr=2
    set_cfg(1'b1, 1'b0, 0, 2, 0);
    v(4'b1000, 7'b0000000, 0);
    v(4'b0000, 7'b1000010, 0);
    v(4'b0000, 7'b1000000, 0);
    v(4'b0000, 7'b1000000, 0);
    v(4'b0000, 7'b1000010, 0);
    for (int k = 0; k < 2; k++) begin
      v(4'b0000, 7'b1100000, 0);
      v(4'b0000, 7'b1000000, 0);
      v(4'b0000, 7'b1000010, 0);
    end
    v(4'b0000, 7'b1100000, 0);
    v(4'b0100, 7'b1001000, 0);
    v(4'b0000, 7'b0000000, 0);
    // 5: start+stop together while running, then restart mid-run
    set_cfg(1'b1, 1'b0, 4, 0, 0);
    v(4'b1000, 7'b0000000, 0);
    v(4'b0000, 7'b1000010, 0);
    v(4'b0000, 7'b1000100, 0);
    v(4'b0000, 7'b1000100, 1);
    set_cfg(1'b0, 1'b1, 9, 0, 9);
    v(4'b1100, 7'b1001000, 2);
    v(4'b0000, 7'b0000000, 0);
    set_cfg(1'b1, 1'b0, 4, 0, 0);
    v(4'b1000, 7'b0000000, 0);
    v(4'b0000, 7'b1000010, 0);
    v(4'b0000, 7'b1000100, 0);
    v(4'b0000, 7'b1000100, 1);
    set_cfg(1'b0, 1'b1, 9, 0, 9);
    v(4'b1000, 7'b1000000, 2);
    v(4'b0000, 7'b1000011, 2);
    for (int k = 0; k < 9; k++) v(4'b0000, 7'b1000101, 9 - k);
    v(4'b0000, 7'b1000001, 0);
    v(4'b0000, 7'b0100001, 0);
    v(4'b0000, 7'b0000001, 0);
    // 6: overflow error, sticky, cleared by start; reset mid-run
    set_cfg(1'b1, 1'b1, 4, 0, 4);
    v(4'b1000, 7'b0000001, 0);
    v(4'b0000, 7'b1000011, 0);
    v(4'b0001, 7'b1000101, 4);
    v(4'b0000, 7'b1010101, 3);
    v(4'b0000, 7'b1010101, 2);
    v(4'b1000, 7'b1010001, 1);
    v(4'b0001, 7'b1000011, 1);
    v(4'b0001, 7'b1000101, 4);
    v(4'b0010, 7'b1010101, 3);
    v(4'b0000, 7'b0000000, 0);
    v(4'b0000, 7'b0000000, 0);
  endtask

  vec_t e;
  int   n;
  bit   seen;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    reload = '0; pscr = '0; ovf_force = 1'b0;
    fill_table();
    repeat (2) @(posedge clk);

    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      rst = tbl[k].rst; start = tbl[k].start; stop = tbl[k].stop;
      ovf_force = tbl[k].ovf; mode = tbl[k].mode; dir = tbl[k].dir;
      reload = tbl[k].reload; pscr = tbl[k].pscr;
      exp_q.push_back(tbl[k]);
      @(negedge clk);
      cur_idx = k;
      e = exp_q.pop_front();
      chk1("busy", busy, e.busy);
      chk1("irq", irq, e.irq);
      chk1("err", err, e.err);
      chk1("clr", cnt_clr, e.clr);
      chk1("en", cnt_en, e.en);
      chk1("load", cnt_load, e.load);
      chk1("down", cnt_down, e.down);
      chkw("cnt", cnt_q, e.cnt);
      if (e.load) chkw("ldv", cnt_dat, e.ldv);
    end

    // Periodic up reload=2 pscr=1: first irq 8 cycles after start, then every 6.
    cur_idx = -1;
    @(posedge clk);
    #1;
    rst = 1'b0; stop = 1'b0; ovf_force = 1'b0;
    mode = 1'b1; dir = 1'b0; reload = 16'd2; pscr = 8'd1; start = 1'b1;
    @(negedge clk);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      n++;
      if (irq) seen = 1'b1;
    end
    chkw("first_irq_delay", DW'(n), 16'd8);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (irq) seen = 1'b1;
    end
    chkw("irq_interval", DW'(n), 16'd6);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    chk1("busy_after_stop", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
